// File: rtl/xy_point_scan.sv
// Point sequencer for the XY-mode pong scene: one (x, y) DAC coordinate per
// rising edge of the 100 kHz point strobe, cycling ball raster, left paddle, right paddle.
module xy_point_scan #(
    parameter int         BALL_SIZE = 4,
    parameter int         PAD_LEN   = 16,
    parameter logic [7:0] PAD_L_X   = 8'd8,
    parameter logic [7:0] PAD_R_X   = 8'd247
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       clk_100k,
    input  logic [7:0] ball_x,
    input  logic [7:0] ball_y,
    input  logic [7:0] pad_l_y,
    input  logic [7:0] pad_r_y,
    output logic [7:0] dac_x,
    output logic [7:0] dac_y,
    output logic       blank,
    output logic       frame_done
);

    localparam int BALL_PTS = BALL_SIZE * BALL_SIZE;
    localparam int MAX_PTS  = (BALL_PTS > PAD_LEN) ? BALL_PTS : PAD_LEN;
    localparam int IDX_W    = (MAX_PTS > 1) ? $clog2(MAX_PTS) : 1;

    localparam logic [IDX_W-1:0] BALL_LAST = IDX_W'(BALL_PTS - 1);
    localparam logic [IDX_W-1:0] PAD_LAST  = IDX_W'(PAD_LEN - 1);

    typedef enum logic [1:0] {
        S_BALL,
        S_PADL,
        S_PADR
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             clk_d;
    logic             tick;
    logic             latch;
    logic [7:0]       sh_ball_x, sh_ball_y, sh_pad_l_y, sh_pad_r_y;
    logic [7:0]       eff_ball_x, eff_ball_y;
    logic [IDX_W-1:0] dx, dy;
    logic [7:0]       dac_x_nxt, dac_y_nxt;
    logic             blank_nxt, frame_done_nxt;

    // Sums are widened so an offset past 255 clamps instead of wrapping.
    function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [IDX_W-1:0] off);
        logic [IDX_W+8:0] sum;
        sum = {{(IDX_W + 1){1'b0}}, base} + {9'd0, off};
        return (|sum[IDX_W+8:8]) ? 8'hFF : sum[7:0];
    endfunction

    assign tick  = clk_100k & ~clk_d;
    assign latch = tick && (state == S_BALL) && (idx == '0);

    // The first point of a frame uses the live inputs, the rest use the snapshot.
    assign eff_ball_x = latch ? ball_x : sh_ball_x;
    assign eff_ball_y = latch ? ball_y : sh_ball_y;
    assign dx = IDX_W'(32'(idx) % 32'(BALL_SIZE));
    assign dy = IDX_W'(32'(idx) / 32'(BALL_SIZE));

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        dac_x_nxt      = dac_x;
        dac_y_nxt      = dac_y;
        blank_nxt      = blank;
        frame_done_nxt = 1'b0;
        if (tick) begin
            blank_nxt = (idx == '0);
            idx_nxt   = idx + 1'b1;
            case (state)
                S_BALL: begin
                    dac_x_nxt = sat_add(eff_ball_x, dx);
                    dac_y_nxt = sat_add(eff_ball_y, dy);
                    if (idx == BALL_LAST) begin
                        state_nxt = S_PADL;
                        idx_nxt   = '0;
                    end
                end
                S_PADL: begin
                    dac_x_nxt = PAD_L_X;
                    dac_y_nxt = sat_add(sh_pad_l_y, idx);
                    if (idx == PAD_LAST) begin
                        state_nxt = S_PADR;
                        idx_nxt   = '0;
                    end
                end
                S_PADR: begin
                    dac_x_nxt = PAD_R_X;
                    dac_y_nxt = sat_add(sh_pad_r_y, idx);
                    if (idx == PAD_LAST) begin
                        state_nxt      = S_BALL;
                        idx_nxt        = '0;
                        frame_done_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_BALL;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_BALL;
            idx        <= '0;
            clk_d      <= 1'b0;
            sh_ball_x  <= 8'd0;
            sh_ball_y  <= 8'd0;
            sh_pad_l_y <= 8'd0;
            sh_pad_r_y <= 8'd0;
            dac_x      <= 8'd0;
            dac_y      <= 8'd0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            clk_d      <= clk_100k;
            dac_x      <= dac_x_nxt;
            dac_y      <= dac_y_nxt;
            blank      <= blank_nxt;
            frame_done <= frame_done_nxt;
            if (latch) begin
                sh_ball_x  <= ball_x;
                sh_ball_y  <= ball_y;
                sh_pad_l_y <= pad_l_y;
                sh_pad_r_y <= pad_r_y;
            end
        end
    end

endmodule

// File: tb/tb_xy_point_scan.sv
// Scoreboard bench for xy_point_scan: a frame-position model predicts each point,
// a passive monitor compares on every strobe edge and checks outputs hold in between.
module tb_xy_point_scan;

    localparam int BALL_SIZE = 4;
    localparam int PAD_LEN   = 16;
    localparam int PAD_L_X   = 8;
    localparam int PAD_R_X   = 247;
    localparam int BALL_PTS  = BALL_SIZE * BALL_SIZE;
    localparam int FRAME_LEN = BALL_PTS + 2 * PAD_LEN;

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_100k = 1'b0;
    logic [7:0] ball_x = 8'd0, ball_y = 8'd0, pad_l_y = 8'd0, pad_r_y = 8'd0;
    logic [7:0] dac_x, dac_y;
    logic       blank, frame_done;

    xy_point_scan #(
        .BALL_SIZE(BALL_SIZE),
        .PAD_LEN  (PAD_LEN),
        .PAD_L_X  (8'(PAD_L_X)),
        .PAD_R_X  (8'(PAD_R_X))
    ) dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .clk_100k  (clk_100k),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .pad_l_y   (pad_l_y),
        .pad_r_y   (pad_r_y),
        .dac_x     (dac_x),
        .dac_y     (dac_y),
        .blank     (blank),
        .frame_done(frame_done)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int x;
        int y;
        int blank;
        int fd;
    } exp_t;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;

    // Reference model: frame position plus the snapshot taken at position 0.
    int   m_pos = 0;
    int   m_bx = 0, m_by = 0, m_ly = 0, m_ry = 0;
    int   stim_prev = 0;
    bit   rand_inputs = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: actual=%0d required=%0d at t=%0t", name, actual, expected, $time);
    endtask

    function automatic int sat(input int a);
        return (a > 255) ? 255 : a;
    endfunction

    task automatic modelTick();
        exp_t e;
        int   j;
        if (m_pos == 0) begin
            m_bx = int'(ball_x);
            m_by = int'(ball_y);
            m_ly = int'(pad_l_y);
            m_ry = int'(pad_r_y);
        end
        e.fd = 0;
        if (m_pos < BALL_PTS) begin
            e.x     = sat(m_bx + m_pos % BALL_SIZE);
            e.y     = sat(m_by + m_pos / BALL_SIZE);
            e.blank = (m_pos == 0) ? 1 : 0;
        end else if (m_pos < BALL_PTS + PAD_LEN) begin
            j       = m_pos - BALL_PTS;
            e.x     = PAD_L_X;
            e.y     = sat(m_ly + j);
            e.blank = (j == 0) ? 1 : 0;
        end else begin
            j       = m_pos - BALL_PTS - PAD_LEN;
            e.x     = PAD_R_X;
            e.y     = sat(m_ry + j);
            e.blank = (j == 0) ? 1 : 0;
            e.fd    = (j == PAD_LEN - 1) ? 1 : 0;
        end
        exp_q.push_back(e);
        m_pos = (m_pos + 1) % FRAME_LEN;
    endtask

    // Biased toward the top of the range so saturation is hit often.
    function automatic logic [7:0] randCoord();
        return ($urandom_range(0, 1) == 1) ? 8'($urandom_range(230, 255)) : 8'($urandom_range(0, 255));
    endfunction

    task automatic driveLevel(input int level);
        if (level != 0 && stim_prev == 0) begin
            if (rand_inputs && $urandom_range(0, 3) == 0) begin
                ball_x  = randCoord();
                ball_y  = randCoord();
                pad_l_y = randCoord();
                pad_r_y = randCoord();
            end
            modelTick();
        end
        clk_100k  = (level != 0);
        stim_prev = level;
    endtask

    task automatic applyStimulus(input int level, input int cycles);
        repeat (cycles) begin
            @(negedge sysclk);
            driveLevel(level);
        end
    endtask

    task automatic runTicks(input int n, input int hi, input int lo);
        repeat (n) begin
            applyStimulus(1, hi);
            applyStimulus(0, lo);
        end
    endtask

    task automatic runRandomTicks(input int n);
        repeat (n) begin
            applyStimulus(1, $urandom_range(1, 4));
            applyStimulus(0, $urandom_range(1, 4));
        end
    endtask

    task automatic resetDut(input int level);
        @(posedge sysclk);
        #3;
        rst_n    = 1'b0;
        clk_100k = (level != 0);
        #1;
        checkOutput("reset_dac_x", int'(dac_x), 0);
        checkOutput("reset_dac_y", int'(dac_y), 0);
        checkOutput("reset_blank", int'(blank), 1);
        checkOutput("reset_frame_done", int'(frame_done), 0);
        m_pos = 0;
        m_bx  = 0;
        m_by  = 0;
        m_ly  = 0;
        m_ry  = 0;
        repeat (3) @(negedge sysclk);
        rst_n     = 1'b1;
        stim_prev = 0;
        driveLevel(level);
    endtask

    // Monitor: tracks strobe edges on its own and compares one cycle after each.
    initial begin
        int         prev;
        bit         rising;
        exp_t       e;
        logic [7:0] lx, ly;
        logic       lb;
        prev = 0;
        lx   = 8'd0;
        ly   = 8'd0;
        lb   = 1'b1;
        forever begin
            @(posedge sysclk);
            if (!rst_n) begin
                prev = 0;
                lx   = 8'd0;
                ly   = 8'd0;
                lb   = 1'b1;
                continue;
            end
            rising = (clk_100k == 1'b1) && (prev == 0);
            prev   = int'(clk_100k);
            #1;
            if (rising) begin
                checkOutput("sb_has_expectation", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("point_dac_x", int'(dac_x), e.x);
                    checkOutput("point_dac_y", int'(dac_y), e.y);
                    checkOutput("point_blank", int'(blank), e.blank);
                    checkOutput("point_frame_done", int'(frame_done), e.fd);
                    lx = 8'(e.x);
                    ly = 8'(e.y);
                    lb = (e.blank != 0);
                end
            end else begin
                checkOutput("hold_between_ticks", int'({dac_x, dac_y, blank, frame_done}),
                            int'({lx, ly, lb, 1'b0}));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetDut(0);

        // Ball raster and both paddles, plus the wrap back to the ball origin.
        ball_x  = 8'd10;
        ball_y  = 8'd20;
        pad_l_y = 8'd100;
        pad_r_y = 8'd200;
        runTicks(FRAME_LEN + 1, 2, 2);

        // Inputs change at tick 5; the rest of the frame keeps the snapshot.
        resetDut(0);
        ball_x  = 8'd10;
        pad_l_y = 8'd100;
        runTicks(5, 2, 3);
        ball_x  = 8'd50;
        pad_l_y = 8'd30;
        runTicks(FRAME_LEN, 3, 2);

        // Saturation near the top of the DAC range.
        ball_x  = 8'd254;
        ball_y  = 8'd253;
        pad_r_y = 8'd250;
        runTicks(2 * FRAME_LEN, 1, 1);

        // Randomized positions and strobe duty.
        rand_inputs = 1'b1;
        runRandomTicks(6 * FRAME_LEN);

        // Reset mid-frame, then reset released with the strobe already high.
        runRandomTicks(20);
        resetDut(0);
        runRandomTicks(FRAME_LEN);
        runRandomTicks(7);
        resetDut(1);
        applyStimulus(1, 3);
        applyStimulus(0, 2);
        runRandomTicks(FRAME_LEN + 3);
        rand_inputs = 1'b0;

        // Stuck strobe in both polarities.
        applyStimulus(1, 5000);
        applyStimulus(0, 2000);

        // A few points at the real 100 kHz rate.
        runTicks(6, 500, 500);

        repeat (4) @(negedge sysclk);
        checkOutput("queue_empty_at_end", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
